beep_decoder: RTL
=================

// Module: beep_decoder
// PURPOSE
//  Receive side of the buzzer tone interface: samples a square-wave beep line
//  and recovers the note sequence as (period, oscillation count) records.
//  Used as loopback checker / score capture next to the music player.
//  Records leave through a one-entry valid/ready output buffer.
// PARAMETERS
//  PERIOD_W     17      width of measured period, in clk cycles
//  CYC_W        11      width of oscillation count per note
//  TOL          4       max |period - reference| still counted as the same note
//  MIN_CYCLES   2       runs shorter than this are discarded as glitches
//  SILENCE_CYC  131071  clk cycles without a rising edge that end a note;
//                       must be <= 2^PERIOD_W-1
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  beep_in     in   1         square-wave tone input, asynchronous to clk
//  out_valid   out  1         record available
//  out_ready   in   1         consumer accepts record when out_valid && out_ready
//  out_period  out  PERIOD_W  reference period of the note (clk cycles, rise to rise)
//  out_cycles  out  CYC_W     oscillations in the note, saturating
//  drop        out  1         1-cycle pulse: record lost, buffer full
// BEHAVIOUR
//  Reset: all outputs 0; sync flops 0; counters 0; FSM IDLE. Async assert, sync release.
//  Input: 2-flop synchronizer, then rising-edge detect (edge = s1 & ~s2_d).
//  Period counter cnt_p: on edge, captured period p = cnt_p+1 and cnt_p <= 0;
//    otherwise cnt_p <= cnt_p+1. Two edges N clk apart give p = N.
//  Timeout: no edge while cnt_p == SILENCE_CYC-1 -> timeout event; cnt_p held.
//  FSM:
//    IDLE: edge -> SYNC (cnt_p cleared). Timeouts ignored.
//    SYNC: edge -> RUN with ref = p, count = 1. timeout -> IDLE.
//    RUN:  edge with |p-ref| <= TOL -> count += 1 (saturate at 2^CYC_W-1);
//          ref unchanged.
//          edge with |p-ref| > TOL -> close run; new run ref = p, count = 1; stay RUN.
//          timeout -> close run; -> IDLE.
//  Difference is computed at PERIOD_W+1 bits, unsigned magnitude.
//  Close run: if count >= MIN_CYCLES, emit {ref, count}; else discard silently.
//  Emit/buffer:
//    buffer empty, or out_ready=1 this cycle -> load; out_valid=1 next cycle.
//    buffer full and out_ready=0 -> keep old record, drop=1 for one cycle.
//    Handshake with no emit -> out_valid=0 next cycle.
//    out_period/out_cycles stable while out_valid && !out_ready.
//  Latency: out_valid rises 4 clk after the beep_in rise that closes a run
//    (2 sync + 1 detect/compare + 1 buffer), or 1 clk after a timeout event.
//  First edge after reset or IDLE only arms measurement. No record from a partial period.
//  beep_in held high or low forever -> single timeout, FSM stays IDLE, no records.
//  Reset mid-run: run abandoned, no record emitted, buffered record lost.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/SYNC/RUN), default PERIOD_W/CYC_W,
//    SILENCE_CYC constant shared with the music player note tables.
//  Sub-module beep_period_meter: synchronizer + edge detect + cnt_p + timeout;
//    outputs edge, p, timeout. FSM, tolerance compare and output buffer in top.
// TESTING  (TOL=4, MIN_CYCLES=2, SILENCE_CYC=5000 in bench; out_ready=1 unless noted)
//  300 periods of 1000 clk, then beep_in low -> one record (1000,300) ~5000 clk after last rise.
//  5x1000 then 4x1500 then silence -> (1000,5) at first 1500-period edge, then (1500,4).
//  Periods 1000,1003,997,1004,996 then silence -> single record (1000,5); jitter 5 splits.
//  Isolated single period 800 between silences -> no record, drop never asserts.
//  out_ready=0, three notes complete -> first held stable, drop pulses twice; release -> 1 record.
//  rst_n pulsed low mid-note -> outputs 0 within the reset; next note decodes correctly.

Source files
------------

// File: rtl/beep_decoder_pkg.sv
// Shared definitions for the buzzer tone receive path: FSM encoding and the
// default widths/silence length that the music player note tables also use.
package beep_decoder_pkg;

   localparam int PERIOD_W_DEF     = 17;
   localparam int CYC_W_DEF        = 11;
   localparam int NOTE_SILENCE_CYC = 131071;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/beep_decoder_if.sv
// Record output channel of the beep decoder: valid/ready handshake plus the
// buffer-overflow pulse.
interface beep_decoder_if
   import beep_decoder_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int CYC_W    = CYC_W_DEF
);

   logic                out_valid;
   logic                out_ready;
   logic [PERIOD_W-1:0] out_period;
   logic [CYC_W-1:0]    out_cycles;
   logic                drop;

   modport master (
      output out_valid,
      output out_period,
      output out_cycles,
      output drop,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_period,
      input  out_cycles,
      input  drop,
      output out_ready
   );

endinterface

// File: rtl/beep_period_meter.sv
// Synchronises the beep line, detects rising edges and measures the
// rise-to-rise period; flags a single timeout when the line goes silent.
module beep_period_meter #(
   parameter int PERIOD_W    = 17,
   parameter int SILENCE_CYC = 131071
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                beep_in,
   output logic                edge_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                timeout
);

   localparam logic [PERIOD_W-1:0] LIMIT = PERIOD_W'(SILENCE_CYC - 1);

   logic                meta_reg;
   logic                s1_reg;
   logic                s2_d_reg;
   logic [PERIOD_W-1:0] cnt_p_reg;
   logic                timed_out_reg;
   logic                rise;
   logic                at_limit;

   assign rise     = s1_reg & ~s2_d_reg;
   assign at_limit = (cnt_p_reg == LIMIT);

   // Edge, period and timeout are registered so the decode FSM sees them one
   // cycle after detection. The counter parks at the limit until the next rise,
   // and timed_out_reg keeps a long silence from producing repeated timeouts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg      <= 1'b0;
         s1_reg        <= 1'b0;
         s2_d_reg      <= 1'b0;
         cnt_p_reg     <= '0;
         timed_out_reg <= 1'b0;
         edge_pulse    <= 1'b0;
         period        <= '0;
         timeout       <= 1'b0;
      end else begin
         meta_reg   <= beep_in;
         s1_reg     <= meta_reg;
         s2_d_reg   <= s1_reg;
         edge_pulse <= rise;
         timeout    <= 1'b0;
         if (rise) begin
            period        <= cnt_p_reg + 1'b1;
            cnt_p_reg     <= '0;
            timed_out_reg <= 1'b0;
         end else if (at_limit) begin
            timeout       <= ~timed_out_reg;
            timed_out_reg <= 1'b1;
         end else begin
            cnt_p_reg <= cnt_p_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/beep_decoder.sv
// Recovers (period, oscillation count) note records from a buzzer square wave
// and presents them through a one-entry valid/ready buffer.
module beep_decoder
   import beep_decoder_pkg::*;
#(
   parameter int PERIOD_W    = PERIOD_W_DEF,
   parameter int CYC_W       = CYC_W_DEF,
   parameter int TOL         = 4,
   parameter int MIN_CYCLES  = 2,
   parameter int SILENCE_CYC = NOTE_SILENCE_CYC
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           beep_in,
   beep_decoder_if.master out_if
);

   localparam logic [CYC_W-1:0]  CYC_MAX = '1;
   localparam logic [CYC_W-1:0]  CYC_ONE = CYC_W'(1);
   localparam logic [CYC_W-1:0]  CYC_MIN = CYC_W'(MIN_CYCLES);
   localparam logic [PERIOD_W:0] TOL_V   = (PERIOD_W + 1)'(TOL);

   logic                edge_pulse;
   logic [PERIOD_W-1:0] p;
   logic                timeout;

   logic [1:0]          state_reg, state_next;
   logic [PERIOD_W-1:0] ref_reg, ref_next;
   logic [CYC_W-1:0]    count_reg, count_next;
   logic [PERIOD_W:0]   diff;
   logic                in_tol;
   logic                close_run;
   logic                emit;

   logic                valid_reg;
   logic [PERIOD_W-1:0] period_reg;
   logic [CYC_W-1:0]    cycles_reg;
   logic                drop_reg;

   beep_period_meter #(
      .PERIOD_W    (PERIOD_W),
      .SILENCE_CYC (SILENCE_CYC)
   ) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .beep_in    (beep_in),
      .edge_pulse (edge_pulse),
      .period     (p),
      .timeout    (timeout)
   );

   assign diff   = (p >= ref_reg) ? ({1'b0, p} - {1'b0, ref_reg})
                                  : ({1'b0, ref_reg} - {1'b0, p});
   assign in_tol = (diff <= TOL_V);

   // The reference period is fixed by the first period of a run, so slow
   // drift cannot walk a note into a neighbouring pitch.
   always_comb begin
      state_next = state_reg;
      ref_next   = ref_reg;
      count_next = count_reg;
      close_run  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (edge_pulse) state_next = ST_SYNC;
         end
         ST_SYNC: begin
            if (edge_pulse) begin
               state_next = ST_RUN;
               ref_next   = p;
               count_next = CYC_ONE;
            end else if (timeout) begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (edge_pulse) begin
               if (in_tol) begin
                  if (count_reg != CYC_MAX) count_next = count_reg + 1'b1;
               end else begin
                  close_run  = 1'b1;
                  ref_next   = p;
                  count_next = CYC_ONE;
               end
            end else if (timeout) begin
               close_run  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign emit = close_run && (count_reg >= CYC_MIN);

   // A full buffer that is not being drained keeps its record; the newer one
   // is lost and flagged on drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         ref_reg    <= '0;
         count_reg  <= '0;
         valid_reg  <= 1'b0;
         period_reg <= '0;
         cycles_reg <= '0;
         drop_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ref_reg   <= ref_next;
         count_reg <= count_next;
         drop_reg  <= 1'b0;
         if (emit) begin
            if (!valid_reg || out_if.out_ready) begin
               valid_reg  <= 1'b1;
               period_reg <= ref_reg;
               cycles_reg <= count_reg;
            end else begin
               drop_reg <= 1'b1;
            end
         end else if (out_if.out_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign out_if.out_valid  = valid_reg;
   assign out_if.out_period = period_reg;
   assign out_if.out_cycles = cycles_reg;
   assign out_if.drop       = drop_reg;

endmodule
